dic_cmd_ctrl: RTL
=================

Name: dic_cmd_ctrl

Overview:
- Command controller directly upstream of the digital-clock datapath (didp).
- Consumes received ASCII bytes (one-cycle valid strobe from the UART receiver) and drives the datapath's control inputs.
- Control inputs driven: run/freeze, LED digit-select pulse, and the four digit-load strobes with the load value.
- Implements a time-set sequence of four keyed decimal digits: Mtens, Mones, Stens, Sones.

Parameters:
- RUN_AT_RESET, 1, value of dicRun after reset.
- MAX_TENS, 5, largest legal digit for Mtens/Stens.
- MAX_ONES, 9, largest legal digit for Mones/Sones.

Ports:
- clk  input  1  system clock, all state on rising edge.
- rst  input  1  asynchronous, active-low reset.
- rx_data  input  8  received ASCII byte.
- rx_valid  input  1  one-cycle strobe; rx_data valid this cycle.
- dicRun  output  1  1 = clock runs, 0 = frozen.
- dicSelectLEDdisp  output  1  one-cycle pulse; advance LED digit selection.
- ldMtens  output  1  one-cycle load strobe, 10's minutes.
- ldMones  output  1  one-cycle load strobe, 1's minutes.
- ldStens  output  1  one-cycle load strobe, 10's seconds.
- ldSones  output  1  one-cycle load strobe, 1's seconds.
- ld_num  output  4  BCD value to load; valid while any ld* is high, held otherwise.
- o_setMode  output  1  1 while in a SET_* state.
- o_err  output  1  one-cycle pulse on a rejected byte.

Behaviour:
- All outputs registered. Response to a byte accepted at edge N appears in the cycle after edge N (latency 1). No byte is lost: one byte per cycle is fully processed.
- Reset (asynchronous, rst low):
  - state = IDLE, dicRun = RUN_AT_RESET, savedRun = RUN_AT_RESET.
  - All strobes = 0, ld_num = 0, o_setMode = 0, o_err = 0.
  - Reset mid-sequence abandons it; no load strobe is emitted.
- Keys are case-insensitive for letters.
- IDLE state:
  - 'r': dicRun <= 1.
  - 's': dicRun <= 0.
  - 'l': dicSelectLEDdisp pulses 1 cycle.
  - 't': savedRun <= dicRun, dicRun <= 0, state <= SET_MT, o_setMode <= 1.
  - ESC (8'h1B), digits, and any other byte: ignored, no o_err.
- SET_MT -> SET_MO -> SET_ST -> SET_SO:
  - Each state accepts one ASCII digit '0'..'9' (8'h30..8'h39) within its legal range. Legal range is 0..MAX_TENS for MT/ST, 0..MAX_ONES for MO/SO.
  - Legal digit: ld_num <= digit, matching ld* pulses 1 cycle, advance to next state.
  - From SET_SO, a legal digit: ldSones pulses, dicRun <= savedRun, state <= IDLE, o_setMode <= 0.
  - ESC: abort. dicRun <= savedRun, state <= IDLE, no o_err. Digits already loaded stay loaded.
  - Out-of-range digit or any other byte (including 'r','s','l','t'): o_err pulses, state unchanged, no load.
- dicRun is held 0 for the whole time o_setMode = 1.
- dicSelectLEDdisp is never pulsed in SET_* states.
- At most one ld* strobe high in any cycle.
- rx_valid = 0: outputs other than the held ld_num/dicRun/o_setMode return to 0 next cycle.

Decomposition:
- Package dic_pkg:
  - state enum {IDLE, SET_MT, SET_MO, SET_ST, SET_SO}, 3 bits.
  - ASCII constants: KEY_R, KEY_S, KEY_L, KEY_T (upper and lower case), KEY_ESC, ASC_0, ASC_9.
- One combinational sub-module, dic_asc2bcd:
  - Inputs: rx_data and a tens/ones range select.
  - Outputs: is_digit, in_range, bcd[3:0], plus is_run/is_stop/is_led/is_set/is_esc after case folding.
- FSM and output registers live in dic_cmd_ctrl.

Test Plan:
- Reset with RUN_AT_RESET=1: hold rst low, release -> dicRun=1, all strobes 0, ld_num=0, o_setMode=0. Assert rst mid-cycle -> outputs clear immediately.
- IDLE commands:
  - 's' -> dicRun=0 next cycle.
  - 'R' -> dicRun=1.
  - 'l' -> dicSelectLEDdisp high exactly 1 cycle.
  - '7' -> no output change, o_err stays 0.
- Full set sequence, run active: 't','4','2','3','9' on consecutive cycles. Each digit gives one strobe in order, one cycle after its byte:
  - ldMtens with ld_num=4
  - ldMones with ld_num=2
  - ldStens with ld_num=3
  - ldSones with ld_num=9
  - dicRun=0 throughout; after the last digit dicRun=1 and o_setMode=0.
- Range errors: 't' then '6' -> o_err pulse, still SET_MT, no ldMtens. Then '5' -> ldMtens, ld_num=5. Then 'x' -> o_err, state SET_MO.
- Abort with run stopped: 's','t','1',ESC -> ldMtens, ld_num=1 once; then state IDLE, dicRun=0 (restored), no o_err, no further strobes.
- Back-to-back bytes plus reset mid-set: 't','5','9' on consecutive cycles, assert rst before the third digit -> state IDLE, dicRun=RUN_AT_RESET, no ldStens ever emitted.

Source files
------------

// File: rtl/dic_pkg.sv
// Shared types and ASCII key codes for the digital-clock command controller.
package dic_pkg;

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        SET_MT = 3'd1,
        SET_MO = 3'd2,
        SET_ST = 3'd3,
        SET_SO = 3'd4
    } dic_state_e;

    localparam logic [7:0] KEY_R_LC = 8'h72;
    localparam logic [7:0] KEY_R_UC = 8'h52;
    localparam logic [7:0] KEY_S_LC = 8'h73;
    localparam logic [7:0] KEY_S_UC = 8'h53;
    localparam logic [7:0] KEY_L_LC = 8'h6C;
    localparam logic [7:0] KEY_L_UC = 8'h4C;
    localparam logic [7:0] KEY_T_LC = 8'h74;
    localparam logic [7:0] KEY_T_UC = 8'h54;
    localparam logic [7:0] KEY_ESC  = 8'h1B;
    localparam logic [7:0] ASC_0    = 8'h30;
    localparam logic [7:0] ASC_9    = 8'h39;

endpackage

// File: rtl/dic_asc2bcd.sv
// Combinational ASCII decoder: digit/range classification and case-folded
// command-key detection for the command controller.
module dic_asc2bcd
    import dic_pkg::*;
#(
    parameter int unsigned MAX_TENS = 5,
    parameter int unsigned MAX_ONES = 9
) (
    input  logic [7:0] i_rx_data,
    input  logic       i_sel_tens,
    output logic       o_is_digit,
    output logic       o_in_range,
    output logic [3:0] o_bcd,
    output logic       o_is_run,
    output logic       o_is_stop,
    output logic       o_is_led,
    output logic       o_is_set,
    output logic       o_is_esc
);

    localparam logic [3:0] MaxTens = 4'(MAX_TENS);
    localparam logic [3:0] MaxOnes = 4'(MAX_ONES);

    logic [3:0] w_limit;

    assign o_is_digit = (i_rx_data >= ASC_0) && (i_rx_data <= ASC_9);
    assign o_bcd      = i_rx_data[3:0];
    assign w_limit    = i_sel_tens ? MaxTens : MaxOnes;
    assign o_in_range = o_is_digit && (o_bcd <= w_limit);

    assign o_is_run  = (i_rx_data == KEY_R_LC) || (i_rx_data == KEY_R_UC);
    assign o_is_stop = (i_rx_data == KEY_S_LC) || (i_rx_data == KEY_S_UC);
    assign o_is_led  = (i_rx_data == KEY_L_LC) || (i_rx_data == KEY_L_UC);
    assign o_is_set  = (i_rx_data == KEY_T_LC) || (i_rx_data == KEY_T_UC);
    assign o_is_esc  = (i_rx_data == KEY_ESC);

endmodule

// File: rtl/dic_cmd_ctrl.sv
// Command controller: turns received ASCII bytes into run/freeze, LED-select
// and digit-load controls for the digital-clock datapath. All outputs registered.
module dic_cmd_ctrl
    import dic_pkg::*;
#(
    parameter bit          RUN_AT_RESET = 1'b1,
    parameter int unsigned MAX_TENS     = 5,
    parameter int unsigned MAX_ONES     = 9
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [7:0] rx_data,
    input  logic       rx_valid,
    output logic       dicRun,
    output logic       dicSelectLEDdisp,
    output logic       ldMtens,
    output logic       ldMones,
    output logic       ldStens,
    output logic       ldSones,
    output logic [3:0] ld_num,
    output logic       o_setMode,
    output logic       o_err
);

    dic_state_e r_state, w_state_nxt;
    logic       r_run, w_run_nxt;
    logic       r_saved_run, w_saved_run_nxt;
    logic       r_sel, w_sel_nxt;
    logic       r_ld_mt, w_ld_mt_nxt;
    logic       r_ld_mo, w_ld_mo_nxt;
    logic       r_ld_st, w_ld_st_nxt;
    logic       r_ld_so, w_ld_so_nxt;
    logic [3:0] r_ld_num, w_ld_num_nxt;
    logic       r_set_mode;
    logic       r_err, w_err_nxt;

    logic       w_sel_tens;
    logic       w_is_digit, w_in_range;
    logic [3:0] w_bcd;
    logic       w_is_run, w_is_stop, w_is_led, w_is_set, w_is_esc;

    assign w_sel_tens = (r_state == SET_MT) || (r_state == SET_ST);

    dic_asc2bcd #(
        .MAX_TENS (MAX_TENS),
        .MAX_ONES (MAX_ONES)
    ) u_asc2bcd (
        .i_rx_data  (rx_data),
        .i_sel_tens (w_sel_tens),
        .o_is_digit (w_is_digit),
        .o_in_range (w_in_range),
        .o_bcd      (w_bcd),
        .o_is_run   (w_is_run),
        .o_is_stop  (w_is_stop),
        .o_is_led   (w_is_led),
        .o_is_set   (w_is_set),
        .o_is_esc   (w_is_esc)
    );

    always_comb begin
        w_state_nxt     = r_state;
        w_run_nxt       = r_run;
        w_saved_run_nxt = r_saved_run;
        w_sel_nxt       = 1'b0;
        w_ld_mt_nxt     = 1'b0;
        w_ld_mo_nxt     = 1'b0;
        w_ld_st_nxt     = 1'b0;
        w_ld_so_nxt     = 1'b0;
        w_ld_num_nxt    = r_ld_num;
        w_err_nxt       = 1'b0;

        if (rx_valid) begin
            unique case (r_state)
                IDLE: begin
                    if (w_is_run) begin
                        w_run_nxt = 1'b1;
                    end else if (w_is_stop) begin
                        w_run_nxt = 1'b0;
                    end else if (w_is_led) begin
                        w_sel_nxt = 1'b1;
                    end else if (w_is_set) begin
                        w_saved_run_nxt = r_run;
                        w_run_nxt       = 1'b0;
                        w_state_nxt     = SET_MT;
                    end
                end
                SET_MT, SET_MO, SET_ST, SET_SO: begin
                    if (w_is_esc) begin
                        // Abort keeps already-loaded digits; only run state is restored.
                        w_run_nxt   = r_saved_run;
                        w_state_nxt = IDLE;
                    end else if (w_in_range) begin
                        w_ld_num_nxt = w_bcd;
                        unique case (r_state)
                            SET_MT: begin
                                w_ld_mt_nxt = 1'b1;
                                w_state_nxt = SET_MO;
                            end
                            SET_MO: begin
                                w_ld_mo_nxt = 1'b1;
                                w_state_nxt = SET_ST;
                            end
                            SET_ST: begin
                                w_ld_st_nxt = 1'b1;
                                w_state_nxt = SET_SO;
                            end
                            default: begin
                                w_ld_so_nxt = 1'b1;
                                w_run_nxt   = r_saved_run;
                                w_state_nxt = IDLE;
                            end
                        endcase
                    end else begin
                        w_err_nxt = 1'b1;
                    end
                end
                default: begin
                    w_state_nxt = IDLE;
                end
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state     <= IDLE;
            r_run       <= RUN_AT_RESET;
            r_saved_run <= RUN_AT_RESET;
            r_sel       <= 1'b0;
            r_ld_mt     <= 1'b0;
            r_ld_mo     <= 1'b0;
            r_ld_st     <= 1'b0;
            r_ld_so     <= 1'b0;
            r_ld_num    <= 4'd0;
            r_set_mode  <= 1'b0;
            r_err       <= 1'b0;
        end else begin
            r_state     <= w_state_nxt;
            r_run       <= w_run_nxt;
            r_saved_run <= w_saved_run_nxt;
            r_sel       <= w_sel_nxt;
            r_ld_mt     <= w_ld_mt_nxt;
            r_ld_mo     <= w_ld_mo_nxt;
            r_ld_st     <= w_ld_st_nxt;
            r_ld_so     <= w_ld_so_nxt;
            r_ld_num    <= w_ld_num_nxt;
            r_set_mode  <= (w_state_nxt != IDLE);
            r_err       <= w_err_nxt;
        end
    end

    assign dicRun           = r_run;
    assign dicSelectLEDdisp = r_sel;
    assign ldMtens          = r_ld_mt;
    assign ldMones          = r_ld_mo;
    assign ldStens          = r_ld_st;
    assign ldSones          = r_ld_so;
    assign ld_num           = r_ld_num;
    assign o_setMode        = r_set_mode;
    assign o_err            = r_err;

endmodule
